hdl_top: RTL and testbench

HDL_TOP -- requirements
Module: hdl_top

---
 rtl/hdl_top.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_hdl_top.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hdl_top.sv
// hdl_top: register-mapped 8N1 UART with TX/RX FIFOs on a simple slave bus.
//
// Ports:
//   Clk, Rst           system clock (rising edge), synchronous active-high reset
//   SSP_SCK            bus clock pin, kept for pin compatibility, unused
//   SSP_SSEL           slave select, active high
//   SSP_EOC            end-of-cycle strobe, qualifies a register access
//   SSP_WnR            1 = write, 0 = read
//   SSP_RA[2:0]        register address (0 UCR, 1 USR, 2 TDR, 3 RDR, 4 SPR)
//   SSP_DI[11:0]       write data
//   SSP_DO[11:0]       combinational read data, 0 when not reading
//   TxD, RxD           UART serial output (idles high) and input
//   IRQ                registered interrupt request, active high
module hdl_top #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        SSP_SCK,
    input  logic        SSP_SSEL,
    input  logic        SSP_EOC,
    input  logic        SSP_WnR,
    input  logic [2:0]  SSP_RA,
    input  logic [11:0] SSP_DI,
    output logic [11:0] SSP_DO,
    output logic        TxD,
    input  logic        RxD,
    output logic        IRQ
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    logic sck_unused;
    assign sck_unused = SSP_SCK;

    logic wr_en, rd_en;
    assign wr_en = SSP_SSEL & SSP_EOC & SSP_WnR;
    assign rd_en = SSP_SSEL & SSP_EOC & ~SSP_WnR;

    // Control registers
    logic [11:0] ucr_q, spr_q;
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ucr_q <= 12'h000;
            spr_q <= 12'd15;
        end else if (wr_en) begin
            if (SSP_RA == 3'd0) ucr_q <= SSP_DI;
            if (SSP_RA == 3'd4) spr_q <= SSP_DI;
        end
    end

    // TX FIFO
    logic [7:0]      tx_mem [FIFO_DEPTH];
    logic [PtrW-1:0] tx_wp_q, tx_rp_q;
    logic [CntW-1:0] tx_cnt_q;
    logic            tx_empty, tx_full, tx_push, tx_pop;
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CntFull);
    assign tx_push  = wr_en && (SSP_RA == 3'd2) && !tx_full;

    always_ff @(posedge Clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= SSP_DI[7:0];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= (tx_wp_q == PtrLast) ? '0 : tx_wp_q + PtrW'(1);
            if (tx_pop)  tx_rp_q <= (tx_rp_q == PtrLast) ? '0 : tx_rp_q + PtrW'(1);
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CntW'(1);
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CntW'(1);
        end
    end

    // Transmitter
    tx_state_e   tx_state_q, tx_state_d;
    logic [11:0] tx_baud_q, tx_baud_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;
    logic        tx_busy, tx_bit_done;

    assign tx_busy     = (tx_state_q != TxIdle);
    // >= keeps a bit from running away if SPR is lowered mid-bit
    assign tx_bit_done = (tx_baud_q >= spr_q);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q + 12'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_baud_d = 12'd0;
                if (ucr_q[0] && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_mem[tx_rp_q];
                    tx_state_d = TxStart;
                    txd_d      = 1'b0;
                end
            end
            TxStart: begin
                if (tx_bit_done) begin
                    tx_baud_d  = 12'd0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TxData;
                    txd_d      = tx_shift_q[0];
                end
            end
            TxData: begin
                if (tx_bit_done) begin
                    tx_baud_d = 12'd0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            TxStop: begin
                if (tx_bit_done) begin
                    tx_baud_d  = 12'd0;
                    tx_state_d = TxIdle;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            tx_state_q <= TxIdle;
            tx_baud_q  <= 12'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign TxD = txd_q;

    // Receive input synchronizer; loopback taps the registered TxD
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= ucr_q[2] ? txd_q : RxD;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX FIFO, each entry {ferr, data}
    logic [8:0]      rx_mem [FIFO_DEPTH];
    logic [PtrW-1:0] rx_wp_q, rx_rp_q;
    logic [CntW-1:0] rx_cnt_q;
    logic            rx_empty, rx_full, rx_push, rx_pop;
    logic            rx_done, rx_stop_bad;
    logic [7:0]      rx_shift_q, rx_shift_d;

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CntFull);
    assign rx_push  = rx_done && !rx_full;
    assign rx_pop   = rd_en && (SSP_RA == 3'd3) && !rx_empty;

    always_ff @(posedge Clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= {rx_stop_bad, rx_shift_q};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wp_q <= (rx_wp_q == PtrLast) ? '0 : rx_wp_q + PtrW'(1);
            if (rx_pop)  rx_rp_q <= (rx_rp_q == PtrLast) ? '0 : rx_rp_q + PtrW'(1);
            if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CntW'(1);
            else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CntW'(1);
        end
    end

    // Receiver
    rx_state_e   rx_state_q, rx_state_d;
    logic [11:0] rx_baud_q, rx_baud_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [11:0] rx_half;
    logic        rx_bit_done;

    assign rx_half     = 12'((13'(spr_q) + 13'd1) >> 1);
    assign rx_bit_done = (rx_baud_q >= spr_q);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_baud_d   = rx_baud_q + 12'd1;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_done     = 1'b0;
        rx_stop_bad = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                // Count from 1 so the start sample lands half a bit after the edge
                rx_baud_d = 12'd1;
                if (ucr_q[1] && rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_baud_q >= rx_half) begin
                    rx_baud_d  = 12'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_bit_done) begin
                    rx_baud_d  = 12'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RxStop: begin
                if (rx_bit_done) begin
                    rx_baud_d   = 12'd0;
                    rx_done     = 1'b1;
                    rx_stop_bad = ~rx_sync_q;
                    rx_state_d  = RxIdle;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_state_q <= RxIdle;
            rx_baud_q  <= 12'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
        end else begin
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Sticky status flags; a new event in the clearing cycle wins
    logic ferr_q, ovr_q;
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (wr_en && (SSP_RA == 3'd1)) begin
                ferr_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
            if (rx_done && rx_stop_bad) ferr_q <= 1'b1;
            if (rx_done && rx_full)     ovr_q  <= 1'b1;
        end
    end

    logic irq_q;
    always_ff @(posedge Clk) begin
        if (Rst) irq_q <= 1'b0;
        else     irq_q <= (ucr_q[3] & tx_empty & ~tx_busy) | (ucr_q[4] & ~rx_empty);
    end
    assign IRQ = irq_q;

    // Read mux
    logic [11:0] usr, rdr;
    assign usr = {5'b0, tx_busy, ovr_q, ferr_q, rx_full, rx_empty, tx_full, tx_empty};
    assign rdr = rx_empty ? 12'h000 : {3'b0, rx_mem[rx_rp_q]};

    always_comb begin
        SSP_DO = 12'h000;
        if (SSP_SSEL && !SSP_WnR) begin
            case (SSP_RA)
                3'd0:    SSP_DO = ucr_q;
                3'd1:    SSP_DO = usr;
                3'd3:    SSP_DO = rdr;
                3'd4:    SSP_DO = spr_q;
                default: SSP_DO = 12'h000;
            endcase
        end
    end

endmodule

// File: tb/tb_hdl_top.sv
module tb_hdl_top;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        SSP_SCK;
    logic        SSP_SSEL, SSP_EOC, SSP_WnR;
    logic [2:0]  SSP_RA;
    logic [11:0] SSP_DI;
    logic [11:0] SSP_DO;
    logic        TxD, RxD, IRQ;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;
    assign SSP_SCK = Clk;

    hdl_top #(.FIFO_DEPTH(4)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .SSP_SCK  (SSP_SCK),
        .SSP_SSEL (SSP_SSEL),
        .SSP_EOC  (SSP_EOC),
        .SSP_WnR  (SSP_WnR),
        .SSP_RA   (SSP_RA),
        .SSP_DI   (SSP_DI),
        .SSP_DO   (SSP_DO),
        .TxD      (TxD),
        .RxD      (RxD),
        .IRQ      (IRQ)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic reg_wr(input logic [2:0] ra, input logic [11:0] d);
        @(negedge Clk);
        SSP_SSEL = 1'b1; SSP_EOC = 1'b1; SSP_WnR = 1'b1; SSP_RA = ra; SSP_DI = d;
        @(negedge Clk);
        SSP_SSEL = 1'b0; SSP_EOC = 1'b0; SSP_WnR = 1'b0;
    endtask

    // Read without strobe (no side effects)
    task automatic reg_rd(input logic [2:0] ra, output logic [11:0] d);
        @(negedge Clk);
        SSP_SSEL = 1'b1; SSP_EOC = 1'b0; SSP_WnR = 1'b0; SSP_RA = ra;
        #1 d = SSP_DO;
        SSP_SSEL = 1'b0;
    endtask

    // Strobed RDR read, pops the RX FIFO
    task automatic rdr_pop(output logic [11:0] d);
        @(negedge Clk);
        SSP_SSEL = 1'b1; SSP_EOC = 1'b1; SSP_WnR = 1'b0; SSP_RA = 3'd3;
        #1 d = SSP_DO;
        @(negedge Clk);
        SSP_SSEL = 1'b0; SSP_EOC = 1'b0;
    endtask

    // Drive one frame on RxD, 4 cycles per bit (SPR = 3)
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            RxD = frame[i];
            repeat (3) @(negedge Clk);
        end
        @(negedge Clk);
        RxD = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] rd;
        logic [39:0] tx_vec, busy_vec, tx_exp;
        logic [7:0]  byte_v;
        logic [7:0]  bytes [5];
        int          lows;
        bit          found;

        Rst = 1'b1; SSP_SSEL = 1'b0; SSP_EOC = 1'b0; SSP_WnR = 1'b0;
        SSP_RA = 3'd0; SSP_DI = 12'h000; RxD = 1'b1;
        repeat (25) @(negedge Clk);
        Rst = 1'b0;

        // Reset state
        reg_rd(3'd1, rd); check_eq("rst_usr", rd, 12'h005);
        reg_rd(3'd0, rd); check_eq("rst_ucr", rd, 12'h000);
        reg_rd(3'd4, rd); check_eq("rst_spr", rd, 12'd15);
        check_eq("rst_txd", TxD, 1'b1);
        check_eq("rst_irq", IRQ, 1'b0);

        // UCR readback, reserved/write-only reads
        reg_wr(3'd0, 12'hDED);
        reg_rd(3'd0, rd); check_eq("ucr_rb", rd, 12'hDED);
        reg_wr(3'd5, 12'hFFF);
        reg_rd(3'd5, rd); check_eq("ra5_rd", rd, 12'h000);
        reg_rd(3'd2, rd); check_eq("tdr_rd", rd, 12'h000);
        rdr_pop(rd);      check_eq("rdr_empty", rd, 12'h000);

        // Loopback + TxEn with empty TX FIFO: no frame
        reg_wr(3'd0, 12'h005);
        lows = 0;
        repeat (40) begin
            @(negedge Clk);
            if (TxD == 1'b0) lows++;
        end
        check_eq("idle_no_frame", lows, 0);
        reg_rd(3'd1, rd); check_eq("idle_usr", rd, 12'h005);

        // 0x55 frame shape at SPR = 3
        reg_wr(3'd4, 12'd3);
        reg_wr(3'd0, 12'h001);
        reg_wr(3'd2, 12'h055);
        SSP_SSEL = 1'b1; SSP_EOC = 1'b0; SSP_WnR = 1'b0; SSP_RA = 3'd1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge Clk);
            if (TxD == 1'b0) found = 1'b1;
        end
        check_eq("tx55_start", found, 1'b1);
        byte_v = 8'h55;
        for (int i = 0; i < 40; i++) begin
            tx_vec[i]   = TxD;
            busy_vec[i] = SSP_DO[6];
            if (i < 4)       tx_exp[i] = 1'b0;
            else if (i < 36) tx_exp[i] = byte_v[(i - 4) / 4];
            else             tx_exp[i] = 1'b1;
            @(negedge Clk);
        end
        check_eq("tx55_wave", tx_vec, tx_exp);
        check_eq("tx55_busy", busy_vec, 40'hFF_FFFF_FFFF);
        check_eq("tx55_end_txd", TxD, 1'b1);
        check_eq("tx55_end_busy", SSP_DO[6], 1'b0);
        SSP_SSEL = 1'b0;

        // Loopback single byte with RX IRQ
        reg_wr(3'd0, 12'h017);
        reg_wr(3'd2, 12'h0A5);
        repeat (60) @(negedge Clk);
        reg_rd(3'd1, rd); check_eq("lb_rx_nonempty", rd[2], 1'b0);
        check_eq("lb_irq_set", IRQ, 1'b1);
        rdr_pop(rd);      check_eq("lb_rdr", rd, 12'h0A5);
        repeat (3) @(negedge Clk);
        reg_rd(3'd1, rd); check_eq("lb_rx_empty", rd[2], 1'b1);
        check_eq("lb_irq_clr", IRQ, 1'b0);

        // Five bytes into a 4-deep RX FIFO: overrun
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h5A;
        for (int i = 0; i < 5; i++) reg_wr(3'd2, {4'h0, bytes[i]});
        repeat (280) @(negedge Clk);
        reg_rd(3'd1, rd);
        check_eq("ovr_rx_full", rd[3], 1'b1);
        check_eq("ovr_flag", rd[5], 1'b1);
        check_eq("ovr_tx_idle", rd[6], 1'b0);
        for (int i = 0; i < 4; i++) begin
            rdr_pop(rd);
            check_eq($sformatf("ovr_rdr%0d", i), rd, {4'h0, bytes[i]});
        end
        reg_rd(3'd1, rd); check_eq("ovr_drained", rd[2], 1'b1);

        // Framing error from RxD, then clear via USR write
        reg_wr(3'd1, 12'h000);
        reg_rd(3'd1, rd); check_eq("usr_clr_ovr", rd[5], 1'b0);
        reg_wr(3'd0, 12'h002);
        send_rx(8'h3C, 1'b0);
        repeat (12) @(negedge Clk);
        reg_rd(3'd1, rd); check_eq("ferr_flag", rd[4], 1'b1);
        rdr_pop(rd);      check_eq("ferr_rdr", rd, 12'h13C);
        reg_wr(3'd1, 12'hABC);
        reg_rd(3'd1, rd); check_eq("ferr_clr", rd[4], 1'b0);

        // Good RxD frame stores ferr = 0
        send_rx(8'hC3, 1'b1);
        repeat (12) @(negedge Clk);
        rdr_pop(rd);      check_eq("rx_good", rd, 12'h0C3);

        // Reset mid-frame
        reg_wr(3'd0, 12'h001);
        reg_wr(3'd2, 12'h000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge Clk);
            if (TxD == 1'b0) found = 1'b1;
        end
        check_eq("mid_start", found, 1'b1);
        repeat (8) @(negedge Clk);
        check_eq("mid_txd_low", TxD, 1'b0);
        Rst = 1'b1;
        @(negedge Clk);
        check_eq("mid_rst_txd", TxD, 1'b1);
        Rst = 1'b0;
        reg_rd(3'd1, rd); check_eq("mid_rst_usr", rd, 12'h005);
        reg_rd(3'd4, rd); check_eq("mid_rst_spr", rd, 12'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
